// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// controller states and the encoded control-output vectors.
package hazard_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        LU_STALL = 1'b1
    } state_t;

    localparam int REG_ZERO = 0;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_bubble;
        logic pipe_freeze;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET   = 5'b00110;
    localparam ctrl_t CTRL_NORMAL  = 5'b11000;
    localparam ctrl_t CTRL_STALL   = 5'b00010;
    localparam ctrl_t CTRL_BRANCH  = 5'b10110;
    localparam ctrl_t CTRL_JUMP    = 5'b10100;
    localparam ctrl_t CTRL_MEMWAIT = 5'b00001;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear, used for the hazard perf statistics.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use / control hazard controller for the 5-stage pipeline.
// Define HAZARD_PERF_EN to build the three saturating perf counters.
module hazard_stall_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_LAT   = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [REG_ADDR_W-1:0] IF_ID_Rs,
    input  logic [REG_ADDR_W-1:0] IF_ID_Rt,
    input  logic                  IF_ID_UsesRt,
    input  logic                  ID_Jump,
    input  logic                  ID_EX_MemRead,
    input  logic [REG_ADDR_W-1:0] ID_EX_Rt,
    input  logic                  EX_BranchTaken,
    input  logic                  MemBusy,
    output logic                  PCWrite,
    output logic                  IF_ID_Write,
    output logic                  IF_ID_Flush,
    output logic                  ID_EX_Bubble,
    output logic                  PipeFreeze,
    output logic [CNT_W-1:0]      StallCycles,
    output logic [CNT_W-1:0]      FlushCount,
    output logic [CNT_W-1:0]      MemWaitCycles
);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             hazard;
    ctrl_t            ctrl;

    assign hazard = ID_EX_MemRead
                  && (ID_EX_Rt != REG_ADDR_W'(REG_ZERO))
                  && ((ID_EX_Rt == IF_ID_Rs) || (IF_ID_UsesRt && (ID_EX_Rt == IF_ID_Rt)));

    // Priority chain: taken branch, memory wait, load-use stall, jump, normal.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctrl    = CTRL_NORMAL;
        if (EX_BranchTaken) begin
            ctrl    = CTRL_BRANCH;
            state_d = RUN;
            cnt_d   = '0;
        end else if (MemBusy) begin
            ctrl = CTRL_MEMWAIT;
        end else if (state_q == LU_STALL) begin
            ctrl  = CTRL_STALL;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q <= CNT_W'(1)) begin
                state_d = RUN;
                cnt_d   = '0;
            end
        end else if (hazard) begin
            ctrl = CTRL_STALL;
            if (LOAD_LAT > 1) begin
                state_d = LU_STALL;
                cnt_d   = CNT_W'(LOAD_LAT - 1);
            end
        end else if (ID_Jump) begin
            ctrl = CTRL_JUMP;
        end
        // Reset overrides the outputs combinationally so the pipe is quiet while held.
        if (!Rst) begin
            ctrl = CTRL_RESET;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign PCWrite      = ctrl.pc_write;
    assign IF_ID_Write  = ctrl.if_id_write;
    assign IF_ID_Flush  = ctrl.if_id_flush;
    assign ID_EX_Bubble = ctrl.id_ex_bubble;
    assign PipeFreeze   = ctrl.pipe_freeze;

`ifdef HAZARD_PERF_EN
    logic stall_inc;

    // Only bubbles caused by a load-use stall count, not branch flush bubbles.
    assign stall_inc = Rst && !EX_BranchTaken && !MemBusy && ((state_q == LU_STALL) || hazard);

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .Clk   (Clk),
        .Rst   (Rst),
        .inc   (stall_inc),
        .clr   (1'b0),
        .count (StallCycles)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .Clk   (Clk),
        .Rst   (Rst),
        .inc   (Rst && ctrl.if_id_flush),
        .clr   (1'b0),
        .count (FlushCount)
    );

    sat_counter #(.CNT_W(CNT_W)) u_memwait_cnt (
        .Clk   (Clk),
        .Rst   (Rst),
        .inc   (Rst && MemBusy),
        .clr   (1'b0),
        .count (MemWaitCycles)
    );
`else
    assign StallCycles   = '0;
    assign FlushCount    = '0;
    assign MemWaitCycles = '0;
`endif

endmodule
